flex_scan_sequencer: RTL and testbench
======================================

Name: flex_scan_sequencer

Overview:
- Autonomous scan controller that shares one byte-level SPI master among up to 8 single-ended channels of an MCP3008-class 10-bit ADC, one flex sensor per channel.
- Drives chip select and the SPI master's byte handshake, and issues the 3-byte conversion command for each channel in round-robin order.
- Emits one tagged 10-bit sample per conversion and a pulse at the end of each full frame.
- Sits between the SPI master and the glove decode/gesture logic.

Parameters:
- NUM_CH, 5, number of channels scanned (0..NUM_CH-1). Legal range 1..8.
- CS_SETUP_CLKS, 2, clk cycles cs_n is held low before the first byte is issued. Must be >=1.
- CS_IDLE_CLKS, 8, minimum clk cycles cs_n stays high between transactions. Must be >=1.
- CHW, 3, channel index width. Fixed at 3 to cover up to 8 channels.

Ports:
- clk  in  1  system clock; the SPI master runs on the same clock.
- rst  in  1  asynchronous active-low reset.
- i_scan_en  in  1  level; 1 = scan continuously.
- o_tx_byte  out  8  byte to the SPI master.
- o_tx_dv  out  1  one-cycle transmit strobe to the SPI master.
- i_tx_ready  in  1  SPI master idle/ready.
- i_rx_dv  in  1  one-cycle pulse: received byte valid.
- i_rx_byte  in  8  received byte.
- o_cs_n  out  1  ADC chip select, active low.
- o_sample_valid  out  1  one-cycle pulse: new sample.
- o_sample_ch  out  CHW  channel of the sample.
- o_sample_data  out  10  conversion result.
- o_frame_done  out  1  one-cycle pulse, coincident with the sample of channel NUM_CH-1.
- o_busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (async, rst=0):
  - State goes to IDLE and the channel counter to 0.
  - o_cs_n=1, o_tx_dv=0, o_tx_byte=0x00, o_sample_valid=0, o_sample_ch=0, o_sample_data=0, o_frame_done=0, o_busy=0.
  - Reset mid-transaction releases cs_n immediately. No sample is emitted.
- States: IDLE, CS_SETUP, SEND, WAIT_RX, CS_HOLD, GAP.
- IDLE:
  - cs_n=1.
  - If i_scan_en=1, go to CS_SETUP next cycle and drive cs_n=0 from that cycle.
- CS_SETUP:
  - cs_n=0.
  - Count CS_SETUP_CLKS cycles, then go to SEND with byte index 0.
- SEND:
  - Wait for i_tx_ready=1.
  - In that cycle, assert o_tx_dv for exactly one cycle with o_tx_byte = byte[idx], then go to WAIT_RX.
  - o_tx_dv is never asserted while i_tx_ready=0.
  - Command bytes: byte0=0x01; byte1={1'b1, ch[2:0], 4'b0000}; byte2=0x00.
- WAIT_RX:
  - On i_rx_dv=1, capture i_rx_byte.
  - idx 1: keep bits [1:0] as data[9:8]. idx 2: keep all 8 bits as data[7:0]. The byte0 response is discarded.
  - If idx<2, increment idx and return to SEND. If idx=2, go to CS_HOLD.
  - i_rx_dv in any other state is ignored.
- CS_HOLD (1 cycle):
  - cs_n=1.
  - Assert o_sample_valid with o_sample_ch=ch and o_sample_data.
  - Assert o_frame_done if ch=NUM_CH-1.
  - ch wraps NUM_CH-1 -> 0, otherwise increments.
  - o_sample_ch/o_sample_data hold their value until the next sample.
- GAP:
  - cs_n=1 for a further CS_IDLE_CLKS-1 cycles, so total cs_n high is >= CS_IDLE_CLKS.
  - Then go to CS_SETUP if i_scan_en=1, else to IDLE.
  - On entering IDLE, ch resets to 0, so each new enable starts at channel 0.
- Scan disable: i_scan_en is sampled only in IDLE and at the end of GAP. Dropping it mid-transaction completes the current conversion and emits its sample.
- Latency: with i_tx_ready permanently 1 and the SPI master turning each byte around in T cycles, one conversion takes 1+CS_SETUP_CLKS+3·(T+1)+CS_IDLE_CLKS cycles.
- NUM_CH=1: always channel 0; o_frame_done fires with every sample.

Test Plan:
- Reset release, i_scan_en=0, 50 cycles -> o_cs_n=1, o_tx_dv=0, o_busy=0, all outputs 0.
- NUM_CH=5, i_scan_en=1, SPI model returns 0x00,0x02,0x5A for every transaction -> bytes 0x01,0x80,0x00 on channel 0; byte1 values 0x80,0x90,0xA0,0xB0,0xC0 for channels 0..4; samples 0x25A tagged 0..4; o_frame_done only with ch=4; sixth sample is ch=0.
- Hold i_tx_ready=0 for 20 cycles inside SEND -> no o_tx_dv pulse; exactly one pulse in the first cycle i_tx_ready returns to 1.
- Spurious i_rx_dv while in GAP and while in CS_SETUP -> no sample, no state change; next sample data is still correct.
- Drop i_scan_en after byte0 of channel 2 -> channel 2 sample still emitted, then IDLE with o_cs_n=1; re-enable -> next transaction uses byte1=0x80 (channel 0).
- Assert rst=0 in WAIT_RX of byte1 -> o_cs_n=1 in the same cycle, no o_sample_valid; after release, scanning restarts at channel 0.

Source files
------------

// File: rtl/flex_scan_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : flex_scan_sequencer_if
// Description : Byte-level SPI handshake between the scan sequencer and a
//               shared SPI master, plus the ADC chip select.
//               master modport : the sequencer (issues bytes, drives cs_n)
//               slave modport  : the SPI master / ADC side
//   o_tx_byte  : byte to transmit
//   o_tx_dv    : one-cycle transmit strobe
//   i_tx_ready : SPI master idle and able to take a byte
//   i_rx_dv    : one-cycle received-byte strobe
//   i_rx_byte  : received byte
//   o_cs_n     : ADC chip select, active low
// Revision    : 1.0 - initial release
// ============================================================================
interface flex_scan_sequencer_if;
  logic [7:0] o_tx_byte;
  logic       o_tx_dv;
  logic       i_tx_ready;
  logic       i_rx_dv;
  logic [7:0] i_rx_byte;
  logic       o_cs_n;

  modport master (
    output o_tx_byte, o_tx_dv, o_cs_n,
    input  i_tx_ready, i_rx_dv, i_rx_byte
  );

  modport slave (
    input  o_tx_byte, o_tx_dv, o_cs_n,
    output i_tx_ready, i_rx_dv, i_rx_byte
  );
endinterface
`default_nettype wire

// File: rtl/flex_scan_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : flex_scan_sequencer
// Description : Round-robin scan controller for an MCP3008-class 10-bit ADC
//               behind a shared byte-level SPI master. For each channel it
//               frames chip select, sends the 3-byte conversion command,
//               assembles the 10-bit result and emits a tagged sample.
//   clk            : system clock (shared with the SPI master)
//   rst            : asynchronous reset, active low
//   i_scan_en      : level, 1 = scan continuously
//   spi            : SPI byte handshake + chip select (master modport)
//   o_sample_valid : one-cycle pulse, new sample available
//   o_sample_ch    : channel of the latest sample
//   o_sample_data  : 10-bit conversion result of the latest sample
//   o_frame_done   : one-cycle pulse with the sample of the last channel
//   o_busy         : high whenever the sequencer is not idle
// Revision    : 1.0 - initial release
// ============================================================================
module flex_scan_sequencer #(
  parameter int NUM_CH        = 5,
  parameter int CS_SETUP_CLKS = 2,
  parameter int CS_IDLE_CLKS  = 8,
  parameter int CHW           = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_scan_en,
  flex_scan_sequencer_if.master spi,
  output logic                  o_sample_valid,
  output logic [CHW-1:0]        o_sample_ch,
  output logic [9:0]            o_sample_data,
  output logic                  o_frame_done,
  output logic                  o_busy
);

  localparam int CNT_MAX = (CS_SETUP_CLKS > CS_IDLE_CLKS) ? CS_SETUP_CLKS : CS_IDLE_CLKS;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] c_SETUP_LAST = CNT_W'(CS_SETUP_CLKS - 1);
  // GAP covers the high time left after the one-cycle CS_HOLD state
  localparam logic [CNT_W-1:0] c_GAP_LAST   = CNT_W'((CS_IDLE_CLKS >= 2) ? (CS_IDLE_CLKS - 2) : 0);
  localparam logic [CHW-1:0]   c_CH_LAST    = CHW'(NUM_CH - 1);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CS_SETUP = 3'd1,
    ST_SEND     = 3'd2,
    ST_WAIT_RX  = 3'd3,
    ST_CS_HOLD  = 3'd4,
    ST_GAP      = 3'd5
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [1:0]       r_idx, w_idx_nxt;
  logic [CHW-1:0]   r_ch, w_ch_nxt, w_ch_wrap;
  logic [1:0]       r_data_hi, w_data_hi_nxt;
  logic             w_sample_load;
  logic             w_tx_dv;
  logic [7:0]       w_tx_byte;
  logic [7:0]       w_cmd_byte;
  logic             w_cs_n_nxt;

  logic             r_cs_n;
  logic             r_sample_valid;
  logic             r_frame_done;
  logic [CHW-1:0]   r_sample_ch;
  logic [9:0]       r_sample_data;

  assign w_ch_wrap = (r_ch == c_CH_LAST) ? '0 : r_ch + CHW'(1);

  // Next-state and combinational outputs
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_idx_nxt     = r_idx;
    w_ch_nxt      = r_ch;
    w_data_hi_nxt = r_data_hi;
    w_sample_load = 1'b0;
    w_tx_dv       = 1'b0;
    w_tx_byte     = 8'h00;

    // MCP3008 single-ended command: start bit, then SGL=1 + channel, then don't-care
    case (r_idx)
      2'd0:    w_cmd_byte = 8'h01;
      2'd1:    w_cmd_byte = {1'b1, r_ch[2:0], 4'b0000};
      default: w_cmd_byte = 8'h00;
    endcase

    case (r_state)
      ST_IDLE: begin
        if (i_scan_en) begin
          w_state_nxt = ST_CS_SETUP;
          w_cnt_nxt   = '0;
        end
      end

      ST_CS_SETUP: begin
        if (r_cnt == c_SETUP_LAST) begin
          w_state_nxt = ST_SEND;
          w_idx_nxt   = 2'd0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end

      ST_SEND: begin
        w_tx_byte = w_cmd_byte;
        // The strobe is gated by ready so it can never be issued to a busy master
        if (spi.i_tx_ready) begin
          w_tx_dv     = 1'b1;
          w_state_nxt = ST_WAIT_RX;
        end
      end

      ST_WAIT_RX: begin
        if (spi.i_rx_dv) begin
          if (r_idx == 2'd1) begin
            w_data_hi_nxt = spi.i_rx_byte[1:0];
          end
          if (r_idx == 2'd2) begin
            w_sample_load = 1'b1;
            w_state_nxt   = ST_CS_HOLD;
          end else begin
            w_idx_nxt   = r_idx + 2'd1;
            w_state_nxt = ST_SEND;
          end
        end
      end

      ST_CS_HOLD: begin
        w_ch_nxt = w_ch_wrap;
        if (CS_IDLE_CLKS > 1) begin
          w_state_nxt = ST_GAP;
          w_cnt_nxt   = '0;
        end else if (i_scan_en) begin
          w_state_nxt = ST_CS_SETUP;
          w_cnt_nxt   = '0;
        end else begin
          w_state_nxt = ST_IDLE;
          w_ch_nxt    = '0;
        end
      end

      ST_GAP: begin
        if (r_cnt == c_GAP_LAST) begin
          if (i_scan_en) begin
            w_state_nxt = ST_CS_SETUP;
            w_cnt_nxt   = '0;
          end else begin
            // A fresh enable always starts the frame from channel 0
            w_state_nxt = ST_IDLE;
            w_ch_nxt    = '0;
          end
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    w_cs_n_nxt = !((w_state_nxt == ST_CS_SETUP) ||
                   (w_state_nxt == ST_SEND)     ||
                   (w_state_nxt == ST_WAIT_RX));
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state        <= ST_IDLE;
      r_cnt          <= '0;
      r_idx          <= 2'd0;
      r_ch           <= '0;
      r_data_hi      <= 2'd0;
      r_cs_n         <= 1'b1;
      r_sample_valid <= 1'b0;
      r_frame_done   <= 1'b0;
      r_sample_ch    <= '0;
      r_sample_data  <= 10'd0;
    end else begin
      r_state        <= w_state_nxt;
      r_cnt          <= w_cnt_nxt;
      r_idx          <= w_idx_nxt;
      r_ch           <= w_ch_nxt;
      r_data_hi      <= w_data_hi_nxt;
      r_cs_n         <= w_cs_n_nxt;
      // Sample strobes line up with the CS_HOLD cycle
      r_sample_valid <= w_sample_load;
      r_frame_done   <= w_sample_load && (r_ch == c_CH_LAST);
      if (w_sample_load) begin
        r_sample_ch   <= r_ch;
        r_sample_data <= {r_data_hi, spi.i_rx_byte};
      end
    end
  end

  assign spi.o_tx_byte  = w_tx_byte;
  assign spi.o_tx_dv    = w_tx_dv;
  assign spi.o_cs_n     = r_cs_n;
  assign o_sample_valid = r_sample_valid;
  assign o_sample_ch    = r_sample_ch;
  assign o_sample_data  = r_sample_data;
  assign o_frame_done   = r_frame_done;
  assign o_busy         = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_flex_scan_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_flex_scan_sequencer
// Description : Self-checking bench for flex_scan_sequencer. An SPI master /
//               ADC model answers each command byte after a fixed turnaround
//               and pushes the expected sample to a scoreboard; a monitor
//               pops and compares every emitted sample.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_flex_scan_sequencer;
  localparam int NUM_CH = 5;
  localparam int T_SPI  = 4;

  typedef struct {
    logic [7:0] r0;
    logic [7:0] r1;
    logic [7:0] r2;
    logic [9:0] data;
  } vec_t;

  typedef struct {
    logic [2:0] ch;
    logic [9:0] data;
    logic       frame;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       scan_en = 1'b0;
  logic       sample_valid;
  logic [2:0] sample_ch;
  logic [9:0] sample_data;
  logic       frame_done;
  logic       busy;

  flex_scan_sequencer_if spi_if ();

  flex_scan_sequencer #(
    .NUM_CH(NUM_CH), .CS_SETUP_CLKS(2), .CS_IDLE_CLKS(8), .CHW(3)
  ) dut (
    .clk(clk), .rst(rst), .i_scan_en(scan_en), .spi(spi_if),
    .o_sample_valid(sample_valid), .o_sample_ch(sample_ch),
    .o_sample_data(sample_data), .o_frame_done(frame_done), .o_busy(busy)
  );

  always #5 clk = ~clk;

  vec_t stim_q[$];
  exp_t sb_q[$];
  vec_t cur;
  vec_t def_v = '{8'h00, 8'h02, 8'h5A, 10'h25A};
  vec_t tbl[5];
  int   n_cmp = 0;
  int   n_err = 0;
  int   n_samples = 0;
  int   exp_ch = 0;
  int   bidx = 0;
  int   cnt = 0;
  int   hold_req = 0;
  int   hold_cnt = 0;
  bit   expect_dv_chk = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // SPI master + ADC model: samples the strobe at negedge, reacts just after posedge
  task automatic spi_model();
    logic       seen;
    logic [7:0] sbyte;
    logic       scs;
    logic [7:0] eb;
    exp_t       e;
    forever begin
      @(negedge clk);
      seen  = spi_if.o_tx_dv;
      sbyte = spi_if.o_tx_byte;
      scs   = spi_if.o_cs_n;
      @(posedge clk);
      #1;
      spi_if.i_rx_dv = 1'b0;
      if (expect_dv_chk) begin
        check("tx_dv_on_ready_return", {31'd0, seen}, 32'd1);
        expect_dv_chk = 1'b0;
      end
      if (hold_cnt > 0) begin
        check("tx_dv_while_not_ready", {31'd0, seen}, 32'd0);
        hold_cnt--;
        if (hold_cnt == 0) begin
          spi_if.i_tx_ready = 1'b1;
          expect_dv_chk = 1'b1;
        end
      end else if (seen) begin
        if (bidx == 0) cur = (stim_q.size() > 0) ? stim_q.pop_front() : def_v;
        eb = (bidx == 0) ? 8'h01 : (bidx == 1) ? {1'b1, exp_ch[2:0], 4'h0} : 8'h00;
        check($sformatf("tx_byte%0d_ch%0d", bidx, exp_ch), {24'd0, sbyte}, {24'd0, eb});
        check("cs_n_low_during_tx", {31'd0, scs}, 32'd0);
        spi_if.i_tx_ready = 1'b0;
        cnt = T_SPI;
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          spi_if.i_rx_dv   = 1'b1;
          spi_if.i_rx_byte = (bidx == 0) ? cur.r0 : (bidx == 1) ? cur.r1 : cur.r2;
          if (bidx == 2) begin
            e.ch    = exp_ch[2:0];
            e.data  = cur.data;
            e.frame = (exp_ch == NUM_CH - 1);
            sb_q.push_back(e);
            exp_ch = (exp_ch == NUM_CH - 1) ? 0 : exp_ch + 1;
            bidx = 0;
            spi_if.i_tx_ready = 1'b1;
          end else begin
            bidx++;
            if (hold_req > 0) begin
              hold_cnt = hold_req;
              hold_req = 0;
            end else begin
              spi_if.i_tx_ready = 1'b1;
            end
          end
        end
      end
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (sample_valid) begin
        n_samples++;
        if (sb_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_sample: got ch=%0d data=0x%0h, expected no sample", sample_ch, sample_data);
        end else begin
          e = sb_q.pop_front();
          check("sample_ch", {29'd0, sample_ch}, {29'd0, e.ch});
          check("sample_data", {22'd0, sample_data}, {22'd0, e.data});
          check("frame_done", {31'd0, frame_done}, {31'd0, e.frame});
        end
      end else if (frame_done) begin
        check("frame_done_without_sample", {31'd0, frame_done}, 32'd0);
      end
    end
  endtask

  task automatic wait_samples(input int target, input int budget, input string name);
    int k;
    k = 0;
    while (n_samples < target && k < budget) begin
      @(negedge clk);
      #1;
      k++;
    end
    n_cmp++;
    if (n_samples < target) begin
      n_err++;
      $display("FAIL timeout_%s: samples %0d, required %0d", name, n_samples, target);
    end
  endtask

  initial begin
    int k;
    int target;

    tbl[0] = '{8'hFF, 8'hFF, 8'hFF, 10'h3FF};
    tbl[1] = '{8'hA5, 8'hFC, 8'h00, 10'h000};  // upper bits of byte1 must be dropped
    tbl[2] = '{8'h00, 8'h01, 8'h80, 10'h180};
    tbl[3] = '{8'h3C, 8'h03, 8'h01, 10'h301};
    tbl[4] = '{8'h00, 8'hFE, 8'h7F, 10'h27F};

    spi_if.i_tx_ready = 1'b1;
    spi_if.i_rx_dv    = 1'b0;
    spi_if.i_rx_byte  = 8'h00;
    fork
      spi_model();
      monitor();
    join_none

    // Reset and idle
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    repeat (50) @(posedge clk);
    #3;
    check("idle_cs_n", {31'd0, spi_if.o_cs_n}, 32'd1);
    check("idle_tx_dv", {31'd0, spi_if.o_tx_dv}, 32'd0);
    check("idle_tx_byte", {24'd0, spi_if.o_tx_byte}, 32'd0);
    check("idle_busy", {31'd0, busy}, 32'd0);
    check("idle_sample_valid", {31'd0, sample_valid}, 32'd0);
    check("idle_sample_ch", {29'd0, sample_ch}, 32'd0);
    check("idle_sample_data", {22'd0, sample_data}, 32'd0);
    check("idle_frame_done", {31'd0, frame_done}, 32'd0);

    // One full frame plus wrap to channel 0
    scan_en = 1'b1;
    wait_samples(6, 400, "frame");

    // Spurious rx strobes in GAP and CS_SETUP
    @(posedge clk);
    #3;
    check("cs_n_gap_start", {31'd0, spi_if.o_cs_n}, 32'd1);
    spi_if.i_rx_byte = 8'hFF;
    spi_if.i_rx_dv   = 1'b1;
    repeat (6) @(posedge clk);
    #3;
    check("cs_n_gap_end", {31'd0, spi_if.o_cs_n}, 32'd1);
    @(posedge clk);
    #3;
    check("cs_n_setup", {31'd0, spi_if.o_cs_n}, 32'd0);
    check("busy_setup", {31'd0, busy}, 32'd1);
    spi_if.i_rx_byte = 8'hFF;
    spi_if.i_rx_dv   = 1'b1;
    wait_samples(7, 200, "after_spurious");

    // tx_ready held low inside SEND
    hold_req = 20;
    wait_samples(8, 300, "ready_hold");
    check("hold_consumed", hold_req, 32'd0);

    // Table-driven response vectors
    for (int i = 0; i < 5; i++) stim_q.push_back(tbl[i]);
    wait_samples(13, 600, "table");

    // Drop scan enable after byte0 of channel 2
    k = 0;
    while (!(exp_ch == 2 && bidx == 0 && cnt > 0) && k < 600) begin
      @(posedge clk);
      #3;
      k++;
    end
    check("reach_ch2_byte0", {31'd0, (exp_ch == 2 && bidx == 0 && cnt > 0)}, 32'd1);
    scan_en = 1'b0;
    target = n_samples + 1;
    wait_samples(target, 200, "disable_sample");
    k = 0;
    while (busy && k < 50) begin
      @(posedge clk);
      #3;
      k++;
    end
    check("busy_after_disable", {31'd0, busy}, 32'd0);
    check("cs_n_after_disable", {31'd0, spi_if.o_cs_n}, 32'd1);
    check("sample_ch_holds", {29'd0, sample_ch}, 32'd2);
    repeat (20) @(posedge clk);
    #3;
    check("no_sample_while_disabled", n_samples, target);
    exp_ch = 0;
    scan_en = 1'b1;
    wait_samples(target + 1, 200, "reenable");

    // Reset while waiting for the byte1 response
    k = 0;
    while (!(bidx == 1 && cnt > 0) && k < 200) begin
      @(posedge clk);
      #3;
      k++;
    end
    check("reach_byte1_wait", {31'd0, (bidx == 1 && cnt > 0)}, 32'd1);
    target = n_samples;
    rst = 1'b0;
    #1;
    check("rst_cs_n_immediate", {31'd0, spi_if.o_cs_n}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_sample_valid", {31'd0, sample_valid}, 32'd0);
    cnt = 0;
    bidx = 0;
    hold_cnt = 0;
    expect_dv_chk = 1'b0;
    exp_ch = 0;
    spi_if.i_rx_dv = 1'b0;
    spi_if.i_tx_ready = 1'b1;
    repeat (3) @(posedge clk);
    #3;
    check("no_sample_in_reset", n_samples, target);
    rst = 1'b1;
    wait_samples(target + 2, 300, "after_reset");

    scan_en = 1'b0;
    repeat (40) @(posedge clk);
    #3;
    check("scoreboard_empty", sb_q.size(), 32'd0);
    check("stim_consumed", stim_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not complete, expected completion");
    $fatal(1, "global timeout");
  end

endmodule
`default_nettype wire
